pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller: load-use, EX busy, fetch wait, LSU wait and deferred redirect.
// Optional MEM_WAIT watchdog is enabled with `define PIPE_CTRL_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | normal issue; flush, LSU, EX, load-use, fetch stalls in priority order
// MEM_WAIT | LSU access outstanding; front four stages held, redirect deferred
// FLUSH    | one-cycle issue of the deferred redirect
module pipe_ctrl #(
    parameter int PC_W           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_wait_i,
    input  logic            id_ex_load_i,
    input  logic [4:0]      id_ex_rd_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic            id_rs1_re_i,
    input  logic            id_rs2_re_i,
    input  logic            exu_busy_i,
    input  logic            lsu_req_i,
    input  logic            lsu_ack_i,
    input  logic            flush_req_i,
    input  logic [PC_W-1:0] flush_pc_i,
    output logic [4:0]      stall_o,
    output logic            flush_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_IFU  = 5'b00001;
    localparam logic [4:0] STALL_LDU  = 5'b00011;
    localparam logic [4:0] STALL_EXU  = 5'b00111;
    localparam logic [4:0] STALL_LSU  = 5'b01111;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [4:0]        stall_d;
    logic              flush_d;
    logic [PC_W-1:0]   redir_d;
    logic              load_use;
    logic              to_hit;
    logic              mem_done;

    assign load_use = id_ex_load_i && (id_ex_rd_i != 5'd0) &&
                      ((id_rs1_re_i && (id_rs1_i == id_ex_rd_i)) ||
                       (id_rs2_re_i && (id_rs2_i == id_ex_rd_i)));

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    assign to_hit = (state_q == ST_MEM_WAIT) && !lsu_ack_i && (cnt_q == TO_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && state_d == ST_MEM_WAIT) begin
            cnt_d = 8'd0;
        end else if (state_q == ST_MEM_WAIT && !lsu_ack_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // A watchdog expiry ends MEM_WAIT exactly like an ack.
    assign mem_done = lsu_ack_i || to_hit;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        stall_d   = STALL_NONE;
        flush_d   = 1'b0;
        redir_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    flush_d = 1'b1;
                    redir_d = flush_pc_i;
                end else if (lsu_req_i && !lsu_ack_i) begin
                    stall_d = STALL_LSU;
                    state_d = ST_MEM_WAIT;
                end else if (exu_busy_i) begin
                    stall_d = STALL_EXU;
                end else if (load_use) begin
                    stall_d = STALL_LDU;
                end else if (ifu_wait_i) begin
                    stall_d = STALL_IFU;
                end
            end
            ST_MEM_WAIT: begin
                // First deferred redirect wins; later ones are dropped.
                if (flush_req_i && !pend_q) begin
                    pend_d    = 1'b1;
                    pend_pc_d = flush_pc_i;
                end
                if (mem_done) begin
                    state_d = pend_d ? ST_FLUSH : ST_IDLE;
                end else begin
                    stall_d = STALL_LSU;
                end
            end
            ST_FLUSH: begin
                flush_d   = 1'b1;
                redir_d   = pend_pc_q;
                pend_d    = 1'b0;
                pend_pc_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                pend_d    = 1'b0;
                pend_pc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign stall_o       = rst ? STALL_NONE : stall_d;
    assign flush_o       = rst ? 1'b0 : flush_d;
    assign redirect_pc_o = rst ? '0 : redir_d;
    assign timeout_o     = rst ? 1'b0 : to_hit;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, stall priority, LSU wait, deferred flush, reset discard, watchdog.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_wait, ld, re1, re2, exu, req, ack, freq;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] fpc;
    logic [4:0]  stall;
    logic        flush, tmo;
    logic [31:0] rpc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_wait_i    (ifu_wait),
        .id_ex_load_i  (ld),
        .id_ex_rd_i    (rd),
        .id_rs1_i      (rs1),
        .id_rs2_i      (rs2),
        .id_rs1_re_i   (re1),
        .id_rs2_re_i   (re2),
        .exu_busy_i    (exu),
        .lsu_req_i     (req),
        .lsu_ack_i     (ack),
        .flush_req_i   (freq),
        .flush_pc_i    (fpc),
        .stall_o       (stall),
        .flush_o       (flush),
        .redirect_pc_o (rpc),
        .timeout_o     (tmo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ifu_wait = 0; ld = 0; re1 = 0; re2 = 0; exu = 0;
        req = 0; ack = 0; freq = 0;
        rd = 0; rs1 = 0; rs2 = 0; fpc = 0;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] s, input logic f,
                              input logic [31:0] pc, input logic t);
        #1;
        check({tag, ".stall"}, 64'(stall), 64'(s));
        check({tag, ".flush"}, 64'(flush), 64'(f));
        check({tag, ".pc"},    64'(rpc),   64'(pc));
        check({tag, ".tmo"},   64'(tmo),   64'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "bench hung");
    end

    initial begin
        // reset with every input high
        rst = 1; ifu_wait = 1; ld = 1; re1 = 1; re2 = 1; exu = 1;
        req = 1; ack = 1; freq = 1; rd = 5'h1f; rs1 = 5'h1f; rs2 = 5'h1f; fpc = 32'hffff_ffff;
        next(); expect_out("rst_c0", 5'b00000, 0, 0, 0);
        next(); expect_out("rst_c1", 5'b00000, 0, 0, 0);
        next(); rst = 0; clr();
        expect_out("post_rst", 5'b00000, 0, 0, 0);
        freq = 1; req = 1; fpc = 32'h1234_5678;
        expect_out("post_rst_idle", 5'b00000, 1, 32'h1234_5678, 0);

        // load-use hazards
        next(); clr(); ld = 1; rd = 5; rs2 = 5; re2 = 1;
        expect_out("lu_rs2", 5'b00011, 0, 0, 0);
        next(); clr();
        expect_out("lu_clear", 5'b00000, 0, 0, 0);
        next(); ld = 1; rd = 0; rs2 = 0; re2 = 1;
        expect_out("lu_rd0", 5'b00000, 0, 0, 0);
        next(); clr(); ld = 1; rd = 7; rs1 = 7; re1 = 0; rs2 = 3; re2 = 1;
        expect_out("lu_rs1_dis", 5'b00000, 0, 0, 0);
        re1 = 1;
        expect_out("lu_rs1", 5'b00011, 0, 0, 0);
        ld = 0;
        expect_out("lu_noload", 5'b00000, 0, 0, 0);

        // stall priority
        next(); clr(); exu = 1; ld = 1; rd = 9; rs1 = 9; re1 = 1; ifu_wait = 1;
        expect_out("pri_exu", 5'b00111, 0, 0, 0);
        exu = 0;
        expect_out("pri_lu", 5'b00011, 0, 0, 0);
        ld = 0;
        expect_out("pri_ifu", 5'b00001, 0, 0, 0);

        // LSU req with same-cycle ack: no wait
        next(); clr(); req = 1; ack = 1; exu = 1;
        expect_out("lsu_fast", 5'b00111, 0, 0, 0);
        next(); clr();
        expect_out("lsu_fast_next", 5'b00000, 0, 0, 0);

        // LSU wait, ack 3 cycles later
        next(); req = 1;
        expect_out("mw_c0", 5'b01111, 0, 0, 0);
        next(); clr(); ifu_wait = 1;
        expect_out("mw_c1", 5'b01111, 0, 0, 0);
        next(); clr();
        expect_out("mw_c2", 5'b01111, 0, 0, 0);
        next(); ack = 1;
        expect_out("mw_ack", 5'b00000, 0, 0, 0);
        next(); clr();
        expect_out("mw_idle", 5'b00000, 0, 0, 0);

        // deferred flush, first request wins
        next(); req = 1;
        expect_out("pf_enter", 5'b01111, 0, 0, 0);
        next(); clr(); freq = 1; fpc = 32'h8000_0100;
        expect_out("pf_req1", 5'b01111, 0, 0, 0);
        next(); freq = 1; fpc = 32'h8000_0200;
        expect_out("pf_req2", 5'b01111, 0, 0, 0);
        next(); clr(); ack = 1;
        expect_out("pf_ack", 5'b00000, 0, 0, 0);
        next(); clr(); exu = 1;
        expect_out("pf_flush", 5'b00000, 1, 32'h8000_0100, 0);
        next(); clr();
        expect_out("pf_after", 5'b00000, 0, 0, 0);

        // flush beats exu and lsu in IDLE
        next(); freq = 1; exu = 1; req = 1; fpc = 32'h0000_4000;
        expect_out("fl_pri", 5'b00000, 1, 32'h0000_4000, 0);
        next(); clr();
        expect_out("fl_pri_next", 5'b00000, 0, 0, 0);

        // reset mid-MEM_WAIT discards pending flush
        next(); req = 1;
        expect_out("rd_enter", 5'b01111, 0, 0, 0);
        next(); clr(); freq = 1; fpc = 32'hdead_0000;
        expect_out("rd_pend", 5'b01111, 0, 0, 0);
        next(); clr(); rst = 1; ack = 1;
        expect_out("rd_rst", 5'b00000, 0, 0, 0);
        next(); rst = 0; clr(); ack = 1;
        expect_out("rd_c0", 5'b00000, 0, 0, 0);
        next(); clr();
        expect_out("rd_c1", 5'b00000, 0, 0, 0);
        next();
        expect_out("rd_c2", 5'b00000, 0, 0, 0);

`ifdef PIPE_CTRL_TIMEOUT_EN
        // watchdog: 4th MEM_WAIT cycle times out
        next(); req = 1;
        expect_out("to_enter", 5'b01111, 0, 0, 0);
        next(); clr();
        expect_out("to_c1", 5'b01111, 0, 0, 0);
        next();
        expect_out("to_c2", 5'b01111, 0, 0, 0);
        next();
        expect_out("to_c3", 5'b01111, 0, 0, 0);
        next();
        expect_out("to_c4", 5'b00000, 0, 0, 1);
        next();
        expect_out("to_idle", 5'b00000, 0, 0, 0);
        // timeout with a pending flush goes through FLUSH
        next(); req = 1;
        expect_out("tof_enter", 5'b01111, 0, 0, 0);
        next(); clr(); freq = 1; fpc = 32'h8000_0300;
        expect_out("tof_c1", 5'b01111, 0, 0, 0);
        next(); clr();
        expect_out("tof_c2", 5'b01111, 0, 0, 0);
        next();
        expect_out("tof_c3", 5'b01111, 0, 0, 0);
        next();
        expect_out("tof_c4", 5'b00000, 0, 0, 1);
        next();
        expect_out("tof_flush", 5'b00000, 1, 32'h8000_0300, 0);
        next();
        expect_out("tof_idle", 5'b00000, 0, 0, 0);
`else
        // no watchdog: MEM_WAIT holds until ack
        next(); req = 1;
        expect_out("nto_enter", 5'b01111, 0, 0, 0);
        next(); clr();
        for (int i = 0; i < 6; i++) begin
            expect_out($sformatf("nto_c%0d", i + 1), 5'b01111, 0, 0, 0);
            next();
        end
        ack = 1;
        expect_out("nto_ack", 5'b00000, 0, 0, 0);
        next(); clr();
        expect_out("nto_idle", 5'b00000, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
